a2s_dualrail_rx: RTL and testbench



---
 rtl/a2s_dualrail_rx.sv | 122 ++++++++++++
 tb/tb_a2s_dualrail_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2s_dualrail_rx.sv
// Four-phase dual-rail receiver: synchronizes the rails into ck, handshakes with
// the sender and buffers 1-bit tokens in a small FIFO for the clocked consumer.
module a2s_dualrail_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic ck,
    input  logic reset_b,
    input  logic a_d0,
    input  logic a_d1,
    output logic a_ack,
    output logic z,
    output logic z_valid,
    input  logic en,
    output logic err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACKED = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync0, sync1;
    logic                   s_d0, s_d1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop, full;
    logic             ack_nxt, err_nxt, head_nxt;

    assign s_d0 = sync0[SYNC_STAGES-1];
    assign s_d1 = sync1[SYNC_STAGES-1];
    assign full = (count == CNT_W'(DEPTH));
    assign pop  = en && (count != '0);

    // Handshake FSM: a push only ever happens on the IDLE -> ACKED transition.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        ack_nxt   = a_ack;
        err_nxt   = err;
        unique case (state)
            ST_IDLE: begin
                ack_nxt = 1'b0;
                if (s_d0 && s_d1) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_ERROR;
                end else if ((s_d0 ^ s_d1) && !full) begin
                    push      = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ST_ACKED;
                end
            end
            ST_ACKED: begin
                if (s_d0 && s_d1) begin
                    err_nxt   = 1'b1;
                    ack_nxt   = 1'b0;
                    state_nxt = ST_ERROR;
                end else if (!s_d0 && !s_d1) begin
                    ack_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERROR: ack_nxt = 1'b0;
            default: begin
                ack_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; the head bypasses the array when the pushed entry lands at the head.
    always_comb begin
        rd_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        head_nxt = (push && (wr_ptr == rd_nxt)) ? s_d1 : mem[rd_nxt];
    end

    always_ff @(posedge ck) begin
        if (!reset_b) begin
            sync0   <= '0;
            sync1   <= '0;
            state   <= ST_IDLE;
            a_ack   <= 1'b0;
            err     <= 1'b0;
            mem     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            z       <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            sync0   <= {sync0[SYNC_STAGES-2:0], a_d0};
            sync1   <= {sync1[SYNC_STAGES-2:0], a_d1};
            state   <= state_nxt;
            a_ack   <= ack_nxt;
            err     <= err_nxt;
            if (push) begin
                mem[wr_ptr] <= s_d1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_nxt;
            count   <= count_nxt;
            z_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                z <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_a2s_dualrail_rx.sv
// Directed bench for a2s_dualrail_rx with default SYNC_STAGES=2, DEPTH=4.
module tb_a2s_dualrail_rx;

    logic ck = 1'b0;
    logic reset_b, a_d0, a_d1, en;
    logic a_ack, z, z_valid, err;

    int n_chk  = 0;
    int n_pass = 0;
    logic got_q[$];

    a2s_dualrail_rx dut (
        .ck      (ck),
        .reset_b (reset_b),
        .a_d0    (a_d0),
        .a_d1    (a_d1),
        .a_ack   (a_ack),
        .z       (z),
        .z_valid (z_valid),
        .en      (en),
        .err     (err)
    );

    always #5 ck = ~ck;

    // Consumer view: every accepted head value, sampled mid-cycle.
    always @(negedge ck) begin
        if (reset_b && en && z_valid) got_q.push_back(z);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ck);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        a_d0 = 1'b0;
        a_d1 = 1'b0;
        en = 1'b0;
        tick(2);
        reset_b = 1'b1;
    endtask

    // Full four-phase token with bounded waits on both acknowledge edges.
    task automatic send(input logic b);
        logic ok;
        if (b) a_d1 = 1'b1;
        else   a_d0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_ack_rise", 32'(ok), 32'd1);
        a_d0 = 1'b0;
        a_d1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!a_ack) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_ack_fall", 32'(ok), 32'd1);
    endtask

    // Compares the captured consumer stream (first token in the LSB).
    task automatic check_stream(input string tag, input int n, input logic [31:0] exp);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < got_q.size() && i < 32; i++) v[i] = got_q[i];
        check({tag, "_len"}, 32'(got_q.size()), 32'(n));
        check({tag, "_data"}, v, exp);
    endtask

    initial begin
        logic ok;

        // Reset state and single-token latency
        do_reset();
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_valid", 32'(z_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        en = 1'b1;
        a_d1 = 1'b1;
        tick(2);
        check("t1_ack_early", 32'(a_ack), 32'd0);
        check("t1_valid_early", 32'(z_valid), 32'd0);
        tick();
        check("t1_ack", 32'(a_ack), 32'd1);
        check("t1_z", 32'(z), 32'd1);
        check("t1_valid", 32'(z_valid), 32'd1);
        tick();
        check("t1_valid_popped", 32'(z_valid), 32'd0);
        check("t1_z_hold", 32'(z), 32'd1);
        a_d1 = 1'b0;
        tick(2);
        check("t1_ack_hold", 32'(a_ack), 32'd1);
        tick();
        check("t1_ack_fall", 32'(a_ack), 32'd0);

        // Stream 0,1,1,0 with the consumer always ready
        tick(2);
        got_q.delete();
        send(1'b0);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        tick(3);
        check_stream("stream", 4, 32'b0110);
        check("stream_err", 32'(err), 32'd0);

        // Back-pressure: four tokens fill the FIFO, the fifth is held off
        do_reset();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        send(1'b1);
        a_d0 = 1'b1;
        tick(6);
        check("bp_ack_held", 32'(a_ack), 32'd0);
        check("bp_valid", 32'(z_valid), 32'd1);
        check("bp_head", 32'(z), 32'd1);
        got_q.delete();
        en = 1'b1;
        tick();
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (a_ack) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("bp_fifth_ack", 32'(ok || a_ack), 32'd1);
        a_d0 = 1'b0;
        tick(4);
        check("bp_ack_fall", 32'(a_ack), 32'd0);
        en = 1'b1;
        tick(7);
        check_stream("bp_drain", 5, 32'b01101);
        check("bp_empty", 32'(z_valid), 32'd0);

        // Push and pop on the same edge at count=2
        do_reset();
        send(1'b1);
        send(1'b0);
        got_q.delete();
        a_d1 = 1'b1;
        tick(2);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("pp_ack", 32'(a_ack), 32'd1);
        check("pp_head", 32'(z), 32'd0);
        a_d1 = 1'b0;
        tick(4);
        en = 1'b1;
        tick(5);
        check_stream("pp_order", 3, 32'b101);
        check("pp_empty", 32'(z_valid), 32'd0);

        // Protocol error: sticky, FIFO still drains, no further pushes
        do_reset();
        send(1'b0);
        send(1'b1);
        a_d0 = 1'b1;
        a_d1 = 1'b1;
        tick(2);
        check("err_early", 32'(err), 32'd0);
        tick();
        check("err_set", 32'(err), 32'd1);
        check("err_ack", 32'(a_ack), 32'd0);
        a_d0 = 1'b0;
        a_d1 = 1'b0;
        tick(3);
        a_d1 = 1'b1;
        tick(6);
        check("err_ignored", 32'(a_ack), 32'd0);
        a_d1 = 1'b0;
        got_q.delete();
        en = 1'b1;
        tick(5);
        check_stream("err_drain", 2, 32'b10);
        check("err_sticky", 32'(err), 32'd1);

        // Reset while ACKED with the rail still held
        do_reset();
        a_d1 = 1'b1;
        tick(3);
        check("mr_acked", 32'(a_ack), 32'd1);
        reset_b = 1'b0;
        tick();
        check("mr_ack_low", 32'(a_ack), 32'd0);
        check("mr_empty", 32'(z_valid), 32'd0);
        check("mr_z", 32'(z), 32'd0);
        reset_b = 1'b1;
        tick(2);
        check("mr_not_yet", 32'(a_ack), 32'd0);
        tick();
        check("mr_recapture_ack", 32'(a_ack), 32'd1);
        check("mr_recapture_valid", 32'(z_valid), 32'd1);
        check("mr_recapture_z", 32'(z), 32'd1);
        a_d1 = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
